mos6532_riot: RTL

Bus responder for the 6507 CPU core: RAM, I/O ports and interval timer (6532 RIOT function). It sits on the CPU's 13-bit address, data and R_W_n bus and answers accesses the top-level decoder routes to it. It provides the 128-byte scratch RAM, two 8-bit ports (joystick/console switches) and the frame-timing interval timer with interrupt flags. All state changes occur on the CPU bus clock.

---
 rtl/mos6532_riot.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mos6532_riot.sv
// RIOT bus responder for the 6507: 128-byte RAM, two I/O ports with DDRs,
// interval timer and PA7 edge detector with active-low interrupt output.
// Ports: CLK, RES_n (async, active-low); bus A[6:0], CS, RS_n, R_W_n, Din, Dout;
//        PA_in/PB_in pins, PA_out/PB_out (ORA/ORB), PA_ddr/PB_ddr, IRQ_n.
module mos6532_riot #(
    parameter logic [7:0] TIM_RESET_VAL = 8'hFF
) (
    input  logic       CLK,
    input  logic       RES_n,
    input  logic [6:0] A,
    input  logic       CS,
    input  logic       RS_n,
    input  logic       R_W_n,
    input  logic [7:0] Din,
    output logic [7:0] Dout,
    input  logic [7:0] PA_in,
    input  logic [7:0] PB_in,
    output logic [7:0] PA_out,
    output logic [7:0] PB_out,
    output logic [7:0] PA_ddr,
    output logic [7:0] PB_ddr,
    output logic       IRQ_n
);

    logic [7:0]  ram [0:127];
    logic [7:0]  ora, ddra, orb, ddrb;
    logic [7:0]  intim;
    logic [9:0]  ps;
    logic [10:0] iv;
    logic        tflag, pflag, tie, pie, ep, pa7_prev;

    logic        sel_ram, sel_io, sel_tim;
    logic        ld_tim, ld_edge, rd_intim, rd_flags;
    logic [7:0]  pa_rd, pb_rd;
    logic        pa7_edge, tick, underflow;
    logic [10:0] iv_sel;

    assign sel_ram  = CS & ~RS_n;
    assign sel_io   = CS & RS_n & ~A[2];
    assign sel_tim  = CS & RS_n & A[2];
    assign ld_tim   = sel_tim & ~R_W_n & A[4];
    assign ld_edge  = sel_tim & ~R_W_n & ~A[4];
    assign rd_intim = sel_tim & R_W_n & ~A[0];
    assign rd_flags = sel_tim & R_W_n & A[0];

    assign pa_rd = (PA_in & ~ddra) | (ora & ddra);
    assign pb_rd = (PB_in & ~ddrb) | (orb & ddrb);

    // EP=1 watches for 0->1, EP=0 for 1->0 on the effective PA7 value
    assign pa7_edge  = ep ? (~pa7_prev & pa_rd[7]) : (pa7_prev & ~pa_rd[7]);
    assign tick      = (ps == 10'd0);
    assign underflow = tick & (intim == 8'h00);

    assign PA_out = ora;
    assign PB_out = orb;
    assign PA_ddr = ddra;
    assign PB_ddr = ddrb;
    assign IRQ_n  = ~((tflag & tie) | (pflag & pie));

    always_comb begin
        iv_sel = 11'd1;
        unique case (A[1:0])
            2'b00: iv_sel = 11'd1;
            2'b01: iv_sel = 11'd8;
            2'b10: iv_sel = 11'd64;
            2'b11: iv_sel = 11'd1024;
        endcase
    end

    always_comb begin
        Dout = 8'h00;
        if (CS && R_W_n) begin
            if (!RS_n) begin
                Dout = ram[A];
            end else if (!A[2]) begin
                unique case (A[1:0])
                    2'b00: Dout = pa_rd;
                    2'b01: Dout = ddra;
                    2'b10: Dout = pb_rd;
                    2'b11: Dout = ddrb;
                endcase
            end else if (!A[0]) begin
                Dout = intim;
            end else begin
                Dout = {tflag, pflag, 6'b0};
            end
        end
    end

    // RAM has no reset; contents survive RES_n
    always_ff @(posedge CLK) begin
        if (sel_ram && !R_W_n) ram[A] <= Din;
    end

    always_ff @(posedge CLK or negedge RES_n) begin
        if (!RES_n) begin
            ora      <= 8'h00;
            ddra     <= 8'h00;
            orb      <= 8'h00;
            ddrb     <= 8'h00;
            intim    <= TIM_RESET_VAL;
            iv       <= 11'd1024;
            ps       <= 10'd1023;
            tflag    <= 1'b0;
            pflag    <= 1'b0;
            tie      <= 1'b0;
            pie      <= 1'b0;
            ep       <= 1'b0;
            pa7_prev <= 1'b0;
        end else begin
            if (sel_io && !R_W_n) begin
                unique case (A[1:0])
                    2'b00: ora  <= Din;
                    2'b01: ddra <= Din;
                    2'b10: orb  <= Din;
                    2'b11: ddrb <= Din;
                endcase
            end

            if (ld_tim) begin
                intim <= Din;
                iv    <= iv_sel;
                ps    <= 10'(iv_sel - 11'd1);
            end else if (tick) begin
                intim <= intim - 8'd1;
                if (intim == 8'h00) begin
                    // after underflow count once per cycle until reloaded
                    iv <= 11'd1;
                    ps <= 10'd0;
                end else begin
                    ps <= 10'(iv - 11'd1);
                end
            end else begin
                ps <= ps - 10'd1;
            end

            // load beats underflow; underflow beats the read-clear
            if (ld_tim)         tflag <= 1'b0;
            else if (underflow) tflag <= 1'b1;
            else if (rd_intim)  tflag <= 1'b0;

            if (ld_tim || rd_intim) tie <= A[3];

            if (ld_edge) begin
                ep  <= A[0];
                pie <= A[1];
            end

            if (pa7_edge)      pflag <= 1'b1;
            else if (rd_flags) pflag <= 1'b0;

            pa7_prev <= pa_rd[7];
        end
    end

endmodule
